// File: rtl/rename_record_queue.sv
// Multi-lane circular record queue between rename and commit: up to WR_LANES
// in-order allocations and RD_LANES in-order retirements per cycle.
module rename_record_queue #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned TABLE_DEPTH  = 8,
    parameter int unsigned WR_LANES     = 2,
    parameter int unsigned RD_LANES     = 2,
    parameter int unsigned AF_THRESHOLD = TABLE_DEPTH - 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic [$clog2(WR_LANES+1)-1:0]         wr_count,
    input  logic [WR_LANES*DATA_WIDTH-1:0]        wr_data,
    input  logic [$clog2(RD_LANES+1)-1:0]         rd_count,
    output logic [RD_LANES*DATA_WIDTH-1:0]        rd_data,
    output logic [$clog2(RD_LANES+1)-1:0]         rd_avail,
    output logic [$clog2(TABLE_DEPTH+1)-1:0]      count,
    output logic                                  table_full,
    output logic                                  table_empty,
    output logic                                  almost_full,
    input  logic                                  err_clear,
    output logic                                  overflow_err,
    output logic                                  underflow_err
);

    localparam int unsigned PTR_W = $clog2(TABLE_DEPTH);
    localparam int unsigned CNT_W = $clog2(TABLE_DEPTH + 1);
    localparam int unsigned WC_W  = $clog2(WR_LANES + 1);
    localparam int unsigned RC_W  = $clog2(RD_LANES + 1);

    logic [DATA_WIDTH-1:0] mem [TABLE_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;

    logic                  wr_ok_c;
    logic                  rd_ok_c;
    logic [WC_W-1:0]       wr_amt_c;
    logic [RC_W-1:0]       rd_amt_c;
    logic                  ovf_new_c;
    logic                  udf_new_c;

    // Acceptance is judged on pre-edge occupancy only; no read/write crediting.
    always_comb begin
        wr_ok_c   = 1'b0;
        rd_ok_c   = 1'b0;
        wr_amt_c  = '0;
        rd_amt_c  = '0;
        ovf_new_c = 1'b0;
        udf_new_c = 1'b0;
        if (!flush) begin
            wr_ok_c   = (32'(wr_count) <= WR_LANES) &&
                        (32'(wr_count) <= TABLE_DEPTH - 32'(count));
            rd_ok_c   = (32'(rd_count) <= RD_LANES) &&
                        (32'(rd_count) <= 32'(count));
            ovf_new_c = !wr_ok_c;
            udf_new_c = !rd_ok_c;
            if (wr_ok_c) begin
                wr_amt_c = wr_count;
            end
            if (rd_ok_c) begin
                rd_amt_c = rd_count;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + PTR_W'(rd_amt_c);
                tail  <= tail + PTR_W'(wr_amt_c);
                count <= count + CNT_W'(wr_amt_c) - CNT_W'(rd_amt_c);
            end
            // New error in the same cycle as a clear leaves the flag set.
            overflow_err  <= (overflow_err  && !err_clear) || ovf_new_c;
            underflow_err <= (underflow_err && !err_clear) || udf_new_c;
        end
    end

    // Storage is not reset; lanes beyond wr_count are ignored.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < WR_LANES; i++) begin
            if (wr_ok_c && (i < 32'(wr_amt_c))) begin
                mem[tail + PTR_W'(i)] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < RD_LANES; i++) begin
            rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[head + PTR_W'(i)];
        end
    end

    assign rd_avail    = (32'(count) >= RD_LANES) ? RC_W'(RD_LANES) : RC_W'(count);
    assign table_full  = (32'(count) == TABLE_DEPTH);
    assign table_empty = (count == '0);
    assign almost_full = (32'(count) >= AF_THRESHOLD);

endmodule

// File: tb/tb_rename_record_queue.sv
// Bench for rename_record_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_rename_record_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [1:0]  wr_count;
    logic [15:0] wr_data;
    logic [1:0]  rd_count;
    logic [15:0] rd_data;
    logic [1:0]  rd_avail;
    logic [3:0]  count;
    logic        table_full;
    logic        table_empty;
    logic        almost_full;
    logic        err_clear;
    logic        overflow_err;
    logic        underflow_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_udf;

    rename_record_queue dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr_count     (wr_count),
        .wr_data      (wr_data),
        .rd_count     (rd_count),
        .rd_data      (rd_data),
        .rd_avail     (rd_avail),
        .count        (count),
        .table_full   (table_full),
        .table_empty  (table_empty),
        .almost_full  (almost_full),
        .err_clear    (err_clear),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle, then advance the reference model by the queue rules.
    task automatic apply(input bit fl, input int wc, input logic [15:0] wd,
                         input int rc, input bit clr);
        int  n;
        bit  wok;
        bit  rok;
        flush     = fl;
        wr_count  = 2'(wc);
        wr_data   = wd;
        rd_count  = 2'(rc);
        err_clear = clr;
        @(posedge clk);
        #1;
        n = mq.size();
        if (fl) begin
            mq.delete();
            m_ovf = m_ovf && !clr;
            m_udf = m_udf && !clr;
        end else begin
            wok = (wc <= 2) && (wc <= 8 - n);
            rok = (rc <= 2) && (rc <= n);
            if (rok) repeat (rc) void'(mq.pop_front());
            if (wok) for (int i = 0; i < wc; i++) mq.push_back(wd[i*8 +: 8]);
            m_ovf = (m_ovf && !clr) || !wok;
            m_udf = (m_udf && !clr) || !rok;
        end
        flush     = 1'b0;
        wr_count  = '0;
        rd_count  = '0;
        err_clear = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        flush = 1'b0; wr_count = '0; wr_data = '0; rd_count = '0; err_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        mq.delete(); m_ovf = 0; m_udf = 0;
        @(posedge clk); #1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (table_empty !== 1'b1 || table_full !== 1'b0 || almost_full !== 1'b0) begin
            bad++; $display("FAIL reset_flags got e=%b f=%b af=%b exp e=1 f=0 af=0", table_empty, table_full, almost_full); end
        total++; if (rd_avail !== 2'd0) begin bad++; $display("FAIL reset_avail got=%0d exp=0", rd_avail); end
        total++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
            bad++; $display("FAIL reset_err got=%b%b exp=00", overflow_err, underflow_err); end
        // Mid-fill reset takes effect without a clock edge.
        apply(0, 2, 16'h0201, 0, 0);
        apply(0, 1, 16'h0003, 0, 0);
        total++; if (count !== 4'd3) begin bad++; $display("FAIL midfill_count got=%0d exp=3", count); end
        reset = 1'b0;
        #2;
        total++; if (count !== 4'd0 || table_empty !== 1'b1) begin
            bad++; $display("FAIL async_reset got count=%0d empty=%b exp 0/1", count, table_empty); end
        mq.delete(); m_ovf = 0; m_udf = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_fill;
        logic [15:0] d;
        for (int k = 0; k < 4; k++) begin
            d = {8'(8'h11 + 2*k), 8'(8'h10 + 2*k)};
            apply(0, 2, d, 0, 0);
            total++; if (count !== 4'(2*k + 2)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", count, 2*k+2); end
            total++; if (almost_full !== (2*k + 2 >= 6)) begin bad++; $display("FAIL fill_af got=%b at count=%0d", almost_full, 2*k+2); end
        end
        total++; if (table_full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", table_full); end
        total++; if (rd_data !== 16'h1110) begin bad++; $display("FAIL fill_rd got=%h exp=1110", rd_data); end
        total++; if (rd_avail !== 2'd2) begin bad++; $display("FAIL fill_avail got=%0d exp=2", rd_avail); end
    endtask

    task automatic test_overflow;
        apply(0, 1, 16'h00AA, 0, 0);
        total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow_err); end
        total++; if (count !== 4'd8 || rd_data !== 16'h1110) begin
            bad++; $display("FAIL ovf_state got count=%0d rd=%h exp 8/1110", count, rd_data); end
        apply(0, 0, 16'h0, 0, 1);
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow_err); end
    endtask

    task automatic test_wrap;
        logic [7:0] exp_order[$];
        logic [7:0] nv;
        for (int i = 0; i < 8; i++) exp_order.push_back(8'(8'h10 + i));
        nv = 8'h30;
        for (int k = 0; k < 6; k++) begin
            total++; if (rd_data[7:0] !== exp_order[0] || rd_data[15:8] !== exp_order[1]) begin
                bad++; $display("FAIL wrap_order got=%h exp=%h%h", rd_data, exp_order[1], exp_order[0]); end
            void'(exp_order.pop_front()); void'(exp_order.pop_front());
            if (k == 0) begin
                apply(0, 2, {8'hEE, 8'hEE}, 2, 0);
            end else begin
                apply(0, 2, {8'(nv + 1), nv}, 2, 0);
                exp_order.push_back(nv); exp_order.push_back(8'(nv + 1));
                nv = 8'(nv + 2);
            end
            total++; if (count !== 4'(mq.size()) || count !== 4'd6) begin
                bad++; $display("FAIL wrap_count got=%0d exp=6", count); end
        end
        total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL wrap_ovf got=%b exp=1", overflow_err); end
        while (exp_order.size() >= 2) begin
            total++; if (rd_data[7:0] !== exp_order[0] || rd_data[15:8] !== exp_order[1]) begin
                bad++; $display("FAIL drain_order got=%h exp=%h%h", rd_data, exp_order[1], exp_order[0]); end
            void'(exp_order.pop_front()); void'(exp_order.pop_front());
            apply(0, 0, 16'h0, 2, 0);
        end
        total++; if (table_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", table_empty); end
    endtask

    task automatic test_underflow;
        apply(1, 0, 16'h0, 0, 1);
        apply(0, 1, 16'h0042, 0, 0);
        total++; if (rd_avail !== 2'd1) begin bad++; $display("FAIL udf_avail got=%0d exp=1", rd_avail); end
        apply(0, 1, 16'h0043, 2, 0);
        total++; if (underflow_err !== 1'b1 || overflow_err !== 1'b0) begin
            bad++; $display("FAIL udf_flag got udf=%b ovf=%b exp 1/0", underflow_err, overflow_err); end
        total++; if (count !== 4'd2 || rd_data !== 16'h4342) begin
            bad++; $display("FAIL udf_state got count=%0d rd=%h exp 2/4342", count, rd_data); end
    endtask

    task automatic test_flush;
        apply(0, 2, 16'h0201, 0, 1);
        apply(0, 1, 16'h0003, 0, 0);
        total++; if (count !== 4'd5) begin bad++; $display("FAIL flush_pre got=%0d exp=5", count); end
        apply(1, 2, 16'h7766, 1, 0);
        total++; if (count !== 4'd0 || table_empty !== 1'b1) begin
            bad++; $display("FAIL flush_state got count=%0d empty=%b exp 0/1", count, table_empty); end
        total++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
            bad++; $display("FAIL flush_err got=%b%b exp=00", overflow_err, underflow_err); end
        apply(0, 1, 16'h005A, 0, 0);
        total++; if (rd_data[7:0] !== 8'h5A || count !== 4'd1) begin
            bad++; $display("FAIL flush_write got lane0=%h count=%0d exp 5a/1", rd_data[7:0], count); end
    endtask

    task automatic test_random;
        int wc, rc, n, av;
        bit fl, clr;
        for (int k = 0; k < 400; k++) begin
            wc  = $urandom_range(0, 2);
            rc  = $urandom_range(0, 2);
            if ($urandom_range(0, 15) == 0) wc = 3;
            if ($urandom_range(0, 15) == 0) rc = 3;
            fl  = ($urandom_range(0, 31) == 0);
            clr = ($urandom_range(0, 5) == 0);
            apply(fl, wc, 16'($urandom), rc, clr);
            n  = mq.size();
            av = (n < 2) ? n : 2;
            total++; if (count !== 4'(n)) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", k, count, n); end
            total++; if (table_empty !== (n == 0) || table_full !== (n == 8) || almost_full !== (n >= 6)) begin
                bad++; $display("FAIL rnd_flags cyc=%0d got e=%b f=%b af=%b n=%0d", k, table_empty, table_full, almost_full, n); end
            total++; if (rd_avail !== 2'(av)) begin bad++; $display("FAIL rnd_avail cyc=%0d got=%0d exp=%0d", k, rd_avail, av); end
            for (int i = 0; i < av; i++) begin
                total++; if (rd_data[i*8 +: 8] !== mq[i]) begin
                    bad++; $display("FAIL rnd_lane%0d cyc=%0d got=%h exp=%h", i, k, rd_data[i*8 +: 8], mq[i]); end
            end
            total++; if (overflow_err !== m_ovf || underflow_err !== m_udf) begin
                bad++; $display("FAIL rnd_err cyc=%0d got=%b%b exp=%b%b", k, overflow_err, underflow_err, m_ovf, m_udf); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_wrap();
        test_underflow();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rename_record_queue.md
Name: rename_record_queue

Overview:
- Multi-lane successor to the rename record table: a circular record buffer storing up to WR_LANES records and retiring up to RD_LANES records per cycle.
- Adds an occupancy count, a programmable almost-full flag, flush-to-empty, and sticky overflow/underflow error flags.
- Sits between rename (writer, up to WR_LANES allocations per cycle) and commit (reader, in-order release).

Parameters:
- DATA_WIDTH, 8, bits per record.
- TABLE_DEPTH, 8, number of entries; power of 2, at least 4.
- WR_LANES, 2, maximum records written per cycle; 1..4, at most TABLE_DEPTH.
- RD_LANES, 2, maximum records read per cycle; 1..4, at most TABLE_DEPTH.
- AF_THRESHOLD, TABLE_DEPTH-2, almost_full asserts when count >= AF_THRESHOLD.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low (reset=0 resets).
- flush  in  1  synchronous discard of all entries.
- wr_count  in  $clog2(WR_LANES+1)  number of records to write this cycle, taken from lanes 0..wr_count-1.
- wr_data  in  WR_LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- rd_count  in  $clog2(RD_LANES+1)  number of records to retire this cycle.
- rd_data  out  RD_LANES*DATA_WIDTH  lane i = entry at head+i (mod depth).
- rd_avail  out  $clog2(RD_LANES+1)  min(count, RD_LANES); lanes at or above rd_avail are don't-care.
- count  out  $clog2(TABLE_DEPTH+1)  current occupancy.
- table_full  out  1  count == TABLE_DEPTH.
- table_empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESHOLD.
- err_clear  in  1  clears both sticky error flags.
- overflow_err  out  1  sticky flag: rejected write.
- underflow_err  out  1  sticky flag: rejected read.

Behaviour:
- Reset (async assert, sync-released by the system):
  - head=0, tail=0, count=0.
  - table_empty=1, table_full=0, almost_full=0 (1 only if AF_THRESHOLD==0), rd_avail=0.
  - overflow_err=0, underflow_err=0.
  - Storage contents are not reset; rd_data is don't-care while empty.
- rd_data, rd_avail and the flags are combinational from registered head/count/storage. No read latency: rd_data lane 0 always shows the oldest entry.
- Write acceptance uses the pre-edge count:
  - Accept iff wr_count <= TABLE_DEPTH - count.
  - Writes are all-or-nothing: on reject, nothing is written, tail is unchanged, and overflow_err sets.
  - A same-cycle read does NOT free space for a same-cycle write.
- Read acceptance:
  - Accept iff rd_count <= count (pre-edge).
  - On reject, head is unchanged and underflow_err sets.
  - A same-cycle write does NOT supply data to a same-cycle read; there is no bypass.
- On accept:
  - storage[tail+i] <= wr_lane i for i < wr_count.
  - tail <= tail + wr_count, head <= head + rd_count, both mod TABLE_DEPTH; pointers wrap naturally.
  - count <= count + accepted_wr - accepted_rd.
  - Written data is visible on rd_data the cycle after acceptance.
- Write and read are evaluated independently: one may be rejected while the other is accepted in the same cycle.
- wr_count > WR_LANES or rd_count > RD_LANES is illegal. It is treated as a reject and sets the corresponding error flag.
- flush has priority over wr/rd in the same cycle:
  - head=tail=count=0; any concurrent writes and reads are dropped.
  - flush itself never sets error flags.
- Error flags:
  - Sticky until err_clear.
  - If err_clear and a new error occur in the same cycle, the new error wins (flag ends set).
  - Reset clears both flags.
- Reset asserted mid-operation returns everything to reset state immediately (asynchronous); in-flight writes are lost.

Test Plan:
- Reset: reset=0 for 2 cycles, then 1 -> count=0, table_empty=1, table_full=0, rd_avail=0, both error flags 0; the reset pulse is repeated mid-fill (count=3) and count returns to 0 immediately.
- Dual-lane fill (defaults): four cycles of wr_count=2 with data {0x11,0x10},{0x13,0x12},{0x15,0x14},{0x17,0x16} -> count 2,4,6,8; almost_full asserts once count=6; table_full=1 at 8; rd_data lanes = 0x10,0x11.
- Write when full: with count=8, wr_count=1, data 0xAA -> overflow_err=1, count stays 8, contents unchanged; err_clear=1 for one cycle -> overflow_err=0.
- Wrap-around, mixed traffic: from full, repeat rd_count=2 with wr_count=2 (except the first cycle where full forces wr reject) -> order is preserved across the pointer wrap. Reading 0x10..0x17 then the new values in exact write order, count is constant.
- Underflow / partial: count=1, rd_count=2 -> underflow_err=1, head unchanged, rd_avail=1; a same-cycle wr_count=1 is still accepted -> count=2.
- Flush priority: count=5, flush=1 with wr_count=2 and rd_count=1 in the same cycle -> next cycle count=0, table_empty=1, no error flags; a following write of 0x5A appears on rd_data lane 0.
